// File: rtl/rr_pkg.sv
// Shared constants, state encoding and pointer helper for the 8-way round-robin grant controller.
package rr_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {IDLE, BUSY} state_t;

    // Pointer advance relies on the 3-bit wrap so that 7 rolls over to 0.
    function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] idx);
        return idx + IDXW'(1);
    endfunction

endpackage

// File: rtl/rr_grant_ctrl8_enc.sv
// 8-to-3 one-hot encoder; an all-zero input encodes to index 0.
module onehot_enc8
    import rr_pkg::*;
(
    input  logic [N-1:0]    oh,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl8.sv
// Round-robin grant controller for 8 requesters with registered one-hot grant
// and an optional hold timeout that revokes a grant held too long.
module rr_grant_ctrl8
    import rr_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            rel,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    state_t          state, state_n;
    logic [IDXW-1:0] ptr, ptr_n;
    logic [N-1:0]    grant_r, grant_n;
    logic [CW-1:0]   hold_cnt, hold_n;
    logic            timeout_r, timeout_n;

    logic [IDXW-1:0] search_ptr;
    logic [IDXW-1:0] cand;
    logic [IDXW-1:0] win_idx;
    logic            found;
    logic            owner_req;
    logic            timeout_hit;
    logic            end_evt;

    onehot_enc8 u_enc (
        .oh  (grant_r),
        .idx (grant_idx)
    );

    assign grant       = grant_r;
    assign grant_valid = |grant_r;
    assign timeout     = timeout_r;

    assign owner_req   = req[grant_idx];
    assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD));
    assign end_evt     = rel || !owner_req || timeout_hit;

    // On a release the search starts just past the owner, so the owner ends up last in line.
    assign search_ptr = (state == BUSY) ? next_ptr(grant_idx) : ptr;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = search_ptr + IDXW'(i);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        grant_n   = grant_r;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                grant_n = '0;
                hold_n  = '0;
                if (found) begin
                    grant_n = N'(1) << win_idx;
                    hold_n  = CW'(1);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (end_evt) begin
                    ptr_n     = search_ptr;
                    // A voluntary release or request drop in the same cycle wins over the timeout.
                    timeout_n = timeout_hit && !rel && owner_req;
                    if (found) begin
                        grant_n = N'(1) << win_idx;
                        hold_n  = CW'(1);
                    end else begin
                        grant_n = '0;
                        hold_n  = '0;
                        state_n = IDLE;
                    end
                end else if (hold_cnt != {CW{1'b1}}) begin
                    hold_n = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_r   <= '0;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant_r   <= grant_n;
            hold_cnt  <= hold_n;
            timeout_r <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Directed bench for rr_grant_ctrl8 built with MAX_HOLD=4: a vector table
// followed by hand-written timeout and reset sequences.
module tb_rr_grant_ctrl8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [7:0] req;
        logic       rel;
        logic [7:0] eg;
        logic [2:0] ei;
        logic       ev;
        logic       et;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rr_grant_ctrl8 #(.MAX_HOLD(4), .CW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .rel         (rel),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    function automatic vec_t mk(input string n, input logic r, input logic [7:0] rq, input logic rl,
                                input logic [7:0] eg, input logic [2:0] ei, input logic ev, input logic et);
        vec_t v;
        v.name = n; v.rst_n = r; v.req = rq; v.rel = rl;
        v.eg = eg; v.ei = ei; v.ev = ev; v.et = et;
        return v;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are then sampled there.
    task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic rl);
        rst_n = r;
        req   = rq;
        rel   = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] ei,
                               input logic ev, input logic et);
        checks++;
        if (grant !== eg || grant_idx !== ei || grant_valid !== ev || timeout !== et) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, expected grant=%h idx=%0d valid=%b timeout=%b",
                     name, grant, grant_idx, grant_valid, timeout, eg, ei, ev, et);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        rel   = 1'b0;

        vecs.push_back(mk("reset0",               0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk("reset1",               0, 8'h00, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk($sformatf("idle%0d", i), 1, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk("first_grant",          1, 8'h24, 0, 8'h04, 2, 1, 0));
        vecs.push_back(mk("b2b_rel",              1, 8'h24, 1, 8'h20, 5, 1, 0));
        vecs.push_back(mk("wrap_rel",             1, 8'h24, 1, 8'h04, 2, 1, 0));
        vecs.push_back(mk("back_to_five",         1, 8'h24, 1, 8'h20, 5, 1, 0));
        vecs.push_back(mk("ptr6_pick7",           1, 8'h81, 1, 8'h80, 7, 1, 0));
        vecs.push_back(mk("wrap7_to_0",           1, 8'h81, 1, 8'h01, 0, 1, 0));
        vecs.push_back(mk("rel_to_idle",          1, 8'h00, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk("rel_idle_ignored",     1, 8'h00, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk("idle_rel_with_req",    1, 8'h02, 1, 8'h02, 1, 1, 0));
        vecs.push_back(mk("hold_owner1",          1, 8'h02, 0, 8'h02, 1, 1, 0));
        vecs.push_back(mk("drop1_to_idle",        1, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk("grant3",               1, 8'h08, 0, 8'h08, 3, 1, 0));
        vecs.push_back(mk("drop3",                1, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk("ptr4_pick4",           1, 8'h18, 0, 8'h10, 4, 1, 0));
        vecs.push_back(mk("nonowner_change",      1, 8'h1C, 0, 8'h10, 4, 1, 0));
        vecs.push_back(mk("releaser_alone_wins",  1, 8'h10, 1, 8'h10, 4, 1, 0));
        vecs.push_back(mk("drop4",                1, 8'h00, 0, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].rel);
            checkOutput(vecs[i].name, vecs[i].eg, vecs[i].ei, vecs[i].ev, vecs[i].et);
        end

        // Hold timeout: pointer is 5, so requester 0 wins first and 0/1 alternate every 4 cycles.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 8'h03, 0);
            checkOutput($sformatf("hold01_%0d", k), 8'h01, 0, 1, 0);
        end
        applyStimulus(1, 8'h03, 0);
        checkOutput("timeout_to_1", 8'h02, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 8'h03, 0);
            checkOutput($sformatf("hold02_%0d", k), 8'h02, 1, 1, 0);
        end
        applyStimulus(1, 8'h03, 0);
        checkOutput("timeout_to_0", 8'h01, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 8'h03, 0);
            checkOutput($sformatf("rehold01_%0d", k), 8'h01, 0, 1, 0);
        end
        applyStimulus(1, 8'h03, 1);
        checkOutput("rel_masks_timeout", 8'h02, 1, 1, 0);
        applyStimulus(1, 8'h00, 0);
        checkOutput("drop_after_timeout", 8'h00, 0, 0, 0);

        // Reset in the middle of a grant clears everything and the pointer.
        applyStimulus(1, 8'h20, 0);
        checkOutput("grant5", 8'h20, 5, 1, 0);
        applyStimulus(0, 8'h20, 0);
        checkOutput("midgrant_reset", 8'h00, 0, 0, 0);
        applyStimulus(1, 8'hFF, 0);
        checkOutput("post_reset_ptr0", 8'h01, 0, 1, 0);
        applyStimulus(1, 8'hFF, 1);
        checkOutput("post_reset_rotate", 8'h02, 1, 1, 0);
        applyStimulus(1, 8'h00, 0);
        checkOutput("final_idle", 8'h00, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
